// File: rtl/ce_piso_tx.sv
// ce_piso_tx -- parallel-in / serial-out transmitter for CE-gated serial chains.
//
// Takes a WIDTH-bit word over a valid/ready handshake, then drives it out on
// Q one bit per clock-enabled edge. Q_VALID marks word bits and LAST marks
// the final bit. A new word can be accepted on the edge that retires the
// last bit, so back-to-back words leave no gap on Q.
//
// Ports
//   CK          in   clock, all state changes on posedge
//   RST_N       in   asynchronous active-low reset
//   CE          in   clock enable, one bit advances per posedge with CE=1
//   DATA_IN     in   [WIDTH-1:0] parallel word
//   LOAD_VALID  in   DATA_IN valid
//   LOAD_READY  out  word can be accepted this cycle (combinational)
//   Q           out  serial data (registered)
//   Q_VALID     out  Q carries a word bit (registered)
//   LAST        out  Q carries the final bit of the word (registered)
//   BUSY        out  word in progress
module ce_piso_tx #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             Q,
  output logic             Q_VALID,
  output logic             LAST,
  output logic             BUSY
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_sr, w_sr_nxt;
  logic             r_q, r_qv, r_last;
  logic             w_ready;
  logic             w_out_bit;

  // Next-state, next shift-register contents and the ready handshake.
  // Ready depends only on state, count and CE, never on LOAD_VALID.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        // The load itself ignores CE; the first bit appears next cycle.
        if (LOAD_VALID) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_sr_nxt    = DATA_IN;
        end
      end
      S_SHIFT: begin
        if (CE) begin
          if (r_cnt == LAST_CNT) begin
            w_ready = 1'b1;
            if (LOAD_VALID) begin
              // Reload on the retiring edge: no gap bit between words.
              w_cnt_nxt = '0;
              w_sr_nxt  = DATA_IN;
            end else begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
              w_sr_nxt    = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
            w_sr_nxt  = MSB_FIRST ? (r_sr << 1) : (r_sr >> 1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_sr_nxt    = '0;
      end
    endcase
  end

  // Output end of the shift register after this edge's update.
  assign w_out_bit = MSB_FIRST ? w_sr_nxt[WIDTH-1] : w_sr_nxt[0];

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_q     <= IDLE_LEVEL;
      r_qv    <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sr    <= w_sr_nxt;
      // Outputs are registered from next-state values so they line up
      // with the state they describe.
      r_q     <= (w_state_nxt == S_SHIFT) ? w_out_bit : IDLE_LEVEL;
      r_qv    <= (w_state_nxt == S_SHIFT);
      r_last  <= (w_state_nxt == S_SHIFT) && (w_cnt_nxt == LAST_CNT);
    end
  end

  assign LOAD_READY = w_ready;
  assign Q          = r_q;
  assign Q_VALID    = r_qv;
  assign LAST       = r_last;
  assign BUSY       = (r_state == S_SHIFT);

endmodule
